// File: rtl/branch_predict_unit.sv
// Branch resolve + direct-mapped BTB with 2-bit counters.
// Ports: lookup_pc->pred_*, res_* resolve in, mispredict/redirect_pc, stats.
package BranchUnitFuncts;
  typedef enum logic [3:0] {
    BEQ  = 4'd0,
    BNE  = 4'd1,
    BLT  = 4'd2,
    BLTU = 4'd3,
    BGE  = 4'd4,
    BGEU = 4'd5,
    JAL  = 4'd6,
    JALR = 4'd7,
    NOP  = 4'd15
  } Type;
endpackage

module branch_predict_unit
  import BranchUnitFuncts::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic [XLEN-1:0] res_op1,
  input  logic [XLEN-1:0] res_op2,
  input  Type             res_funct,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  output logic            res_taken,
  input  logic            flush,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mp_count
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic             mp_q;
  logic [XLEN-1:0]  rd_q;
  logic [31:0]      br_count_q;
  logic [31:0]      mp_count_q;

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic [1:0]       r_ctr;
  logic [1:0]       ctr_nxt;
  logic             is_fn;
  logic             is_jmp;
  logic             is_br;
  logic             mp_cond;
  logic [XLEN-1:0]  redir;
  logic             wr_en;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign l_hit = valid_q[l_idx]
               && (tag_q[l_idx] == l_tag);

  assign pred_taken  = l_hit && ctr_q[l_idx][1];
  assign pred_target = pred_taken
                     ? tgt_q[l_idx]
                     : lookup_pc + XLEN'(4);

  always_comb begin
    res_taken = 1'b0;
    is_fn     = 1'b1;
    is_jmp    = 1'b0;
    case (res_funct)
      BEQ:  res_taken = (res_op1 == res_op2);
      BNE:  res_taken = (res_op1 != res_op2);
      BLT:  res_taken = ($signed(res_op1)
                       < $signed(res_op2));
      BGE:  res_taken = ($signed(res_op1)
                       >= $signed(res_op2));
      BLTU: res_taken = (res_op1 < res_op2);
      BGEU: res_taken = (res_op1 >= res_op2);
      JAL, JALR: begin
        res_taken = 1'b1;
        is_jmp    = 1'b1;
      end
      default: is_fn = 1'b0;
    endcase
  end

  assign is_br = res_valid && is_fn;

  assign mp_cond = (res_taken != res_pred_taken)
                 || (res_taken && res_pred_taken
                     && (res_pred_target != res_target));

  assign redir = res_taken ? res_target
                           : res_pc + XLEN'(4);

  assign r_idx = res_pc[IDX_W+1:2];
  assign r_tag = res_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign r_hit = valid_q[r_idx]
               && (tag_q[r_idx] == r_tag);
  assign r_ctr = ctr_q[r_idx];

  always_comb begin
    ctr_nxt = r_ctr;
    if (is_jmp)
      ctr_nxt = 2'd3;
    else if (res_taken && !r_hit)
      ctr_nxt = 2'd2;
    else if (res_taken)
      ctr_nxt = (r_ctr == 2'd3) ? r_ctr
                                : r_ctr + 2'd1;
    else
      ctr_nxt = (r_ctr == 2'd0) ? r_ctr
                                : r_ctr - 2'd1;
  end

  // Flush suppresses every table write, including counter updates.
  assign wr_en = is_br && !flush
               && (res_taken || r_hit);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ctr_q[r_idx] <= ctr_nxt;
      if (res_taken) begin
        tag_q[r_idx] <= r_tag;
        tgt_q[r_idx] <= res_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (is_br && res_taken) begin
      valid_q[r_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp_q       <= 1'b0;
      rd_q       <= '0;
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      mp_q <= is_br && mp_cond;
      if (is_br) begin
        rd_q <= redir;
        if (br_count_q != '1)
          br_count_q <= br_count_q + 32'd1;
        if (mp_cond && (mp_count_q != '1))
          mp_count_q <= mp_count_q + 32'd1;
      end
    end
  end

  assign mispredict  = mp_q;
  assign redirect_pc = rd_q;
  assign br_count    = br_count_q;
  assign mp_count    = mp_count_q;

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the single-cycle branch comparator. It combines branch condition evaluation with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. Fetch gets a combinational prediction. Execute resolves the branch, compares the outcome with the prediction carried down the pipe, and receives a registered mispredict/redirect one cycle later. The block sits between the fetch PC mux and the execute stage, and keeps branch/mispredict statistics counters.

## Interface
- XLEN, 32: data and PC width.
- ENTRIES, 64: BTB depth; power of two, ≥2. IDX_W = log2(ENTRIES).
- TAG_W, 8: tag width; requires IDX_W+TAG_W+2 ≤ XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lookup_pc  in  XLEN  fetch PC.
- pred_taken  out  1  predicted taken (combinational).
- pred_target  out  XLEN  predicted next PC (combinational).
- res_valid  in  1  resolve request this cycle.
- res_pc  in  XLEN  PC of the resolving instruction.
- res_op1, res_op2  in  XLEN  compare operands.
- res_funct  in  BranchUnitFuncts::Type  BEQ/BNE/BLT/BLTU/BGE/BGEU/JAL/JALR; any other value means non-branch.
- res_target  in  XLEN  computed target.
- res_pred_taken  in  1  prediction issued at fetch.
- res_pred_target  in  XLEN  target predicted at fetch.
- res_taken  out  1  actual outcome (combinational).
- flush  in  1  synchronous invalidate of all BTB entries.
- mispredict  out  1  registered one-cycle pulse.
- redirect_pc  out  XLEN  registered correct next PC; valid while mispredict=1.
- br_count  out  32  resolved branches, saturating.
- mp_count  out  32  mispredicts, saturating.

## Operation
- Index is pc[IDX_W+1:2]. Tag is pc[IDX_W+TAG_W+1:IDX_W+2]. Each entry holds valid, tag, target and a 2-bit ctr.
- Lookup: hit = valid[idx] && tag match. pred_taken = hit && ctr[1]. pred_target = target when pred_taken, otherwise lookup_pc+4 (modulo 2^XLEN).
- res_taken:
  - BEQ: op1==op2. BNE: op1!=op2.
  - BLT/BGE: signed compare. BLTU/BGEU: unsigned compare.
  - JAL/JALR: 1. Other funct: 0.
  - Evaluated regardless of res_valid.
- A branch means res_valid && funct is one of the 8 codes. Non-branches do not update the table or statistics, and never mispredict.
- Mispredict condition: res_taken != res_pred_taken, or both are 1 and res_pred_target != res_target.
- redirect_pc = res_taken ? res_target : res_pc+4.
- Table update on a branch, applied at the clock edge:
  - Taken and hit: ctr increments, saturating at 3; target ← res_target.
  - Taken and miss: allocate valid=1, new tag, target, ctr=2.
  - JAL/JALR: ctr=3 always.
  - Not taken and hit: ctr decrements, saturating at 0; the entry stays valid.
  - Not taken and miss: no change.
- flush: all valid bits clear at the edge. If flush and a branch arrive together, flush wins and nothing is allocated. mispredict, redirect_pc and the statistics still update.
- Statistics: br_count increments per branch. mp_count increments per mispredict. Both hold at 0xFFFFFFFF. Only rst_n clears them; flush does not.

## Timing
- Reset, asynchronous: mispredict=0, redirect_pc=0, all valid=0, br_count=0, mp_count=0. Tag/target/ctr contents are don't-care. pred_taken=0 while in reset and immediately after.
- Lookup and res_taken: zero latency (combinational).
- mispredict/redirect_pc: registered, visible the cycle after res_valid, one-cycle pulse. Back-to-back resolves give back-to-back independent pulses.
- A table write is visible to lookup from the cycle after the edge. A same-cycle lookup to the index being written sees the old contents.
- rst_n asserted mid-pulse: mispredict drops to 0 immediately, without waiting for a clock edge.

## Test plan
- Reset, lookup_pc=0x100 → pred_taken=0, pred_target=0x104, counters 0.
- BEQ op1=op2=5, res_pc=0x100, target=0x80, pred_taken=0 → res_taken=1. Next cycle: mispredict=1, redirect_pc=0x80, br_count=1, mp_count=1. Lookup 0x100 → pred_taken=1, pred_target=0x80.
- At 0x100 (ctr=2), four not-taken BLT with op1=5, op2=0xFFFFFFFD, pred as issued. Expected sequence:
  - pred_taken goes 1→0→0→0.
  - ctr saturates at 0.
  - First resolve: mispredict with redirect_pc=0x104.
  - Following not-taken predictions do not mispredict.
- Signedness: op1=0xFFFFFFFF, op2=1:
  - BLTU → 0, BGEU → 1.
  - BLT → 1, BGE → 0.
- Aliasing: allocate 0x100, then lookup 0x100+4·ENTRIES (different tag) → miss, pred_target=pc+4. Taken pred with wrong target (0x84 vs 0x80) → mispredict, redirect 0x80.
- Flush with a simultaneous taken JAL → entry not allocated, mispredict still pulses. Reset asserted during the pulse → mispredict=0 immediately. Force br_count=0xFFFFFFFF, resolve a branch → br_count stays 0xFFFFFFFF.
